cm3_stream_acc_if: RTL
======================

# cm3_stream_acc_if

Parametrised AHB-Lite slave front end for streaming accelerators such as the windowed FFT. It places an input FIFO and an output FIFO, each of configurable depth and data width, between the bus and a valid/ready accelerator core. It counts output words per frame and raises a maskable interrupt on frame completion or on a bus-side FIFO error. It replaces the fixed single-register bridge; software moves whole frames with fewer wait-on-status polls.

## Interface
- DW, 32: stream data width, 1..32; bus data is zero-extended or truncated to DW.
- IN_DEPTH, 16: input FIFO depth in words; power of two, ≥2.
- OUT_DEPTH, 16: output FIFO depth in words; power of two, ≥2.
- FRAME_W, 10: width of the frame-length register and the frame word counter.
- hclk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- hready_i, hsel, hwrite  in  1 each  AHB-Lite slave controls.
- htrans  in  2  AHB transfer type; bit1 set = NONSEQ/SEQ.
- haddr  in  16  byte address; decode uses haddr[4:2].
- hwdata  in  32  write data, data phase.
- hresp  out  1  tied 0 (OKAY).
- hready_o  out  1  tied 1 (zero wait states).
- hrdata  out  32  read data, data phase.
- int  out  1  registered interrupt, level.
- acc_data_out  out  DW  input-FIFO head to the core.
- acc_valid_out  out  1  high when EN=1 and the input FIFO is not empty.
- acc_ready_in  in  1  core accepts acc_data_out.
- acc_data_in  in  DW  core result.
- acc_valid_in  in  1  result valid.
- acc_ready_out  out  1  high when EN=1 and the output FIFO is not full.
- acc_mode  out  4  CTRL.MODE, passed to the core.

## Operation
- Address phase is captured when hsel & hready_i & htrans[1]. The captured address and direction apply in the following cycle, the data phase.
- Register map:
  - 0x00 CTRL (RW): [0] EN, [1] IE_DONE, [2] IE_ERR, [3] CLR (write-1 pulse, reads 0), [7:4] MODE.
  - 0x04 STATUS: [0] in_full, [1] in_empty, [2] out_full, [3] out_empty, [4] DONE (W1C), [5] ERR (W1C), [15:8] in_level, [23:16] out_level.
  - 0x08 FRAME_LEN (RW, FRAME_W bits).
  - 0x0C IN_DATA (WO): push.
  - 0x10 OUT_DATA (RO): pop.
  - 0x14 OUT_CNT (RO).
  - Unmapped addresses read 0 and ignore writes.
- IN_DATA write with the input FIFO full: word dropped, ERR set. OUT_DATA read with the output FIFO empty: returns 0, no pop, ERR set.
- OUT_DATA read returns the FIFO head combinationally in the data phase; the pop takes effect at the end of that cycle.
- Stream transfers occur on valid & ready. Each accepted acc_data_in increments OUT_CNT.
- Frame completion: when an accept makes OUT_CNT equal FRAME_LEN, DONE is set and OUT_CNT returns to 0. FRAME_LEN=0 disables DONE; OUT_CNT then wraps modulo 2^FRAME_W.
- EN=0 freezes both stream ports; FIFO contents are kept and bus push/pop remain allowed.
- int is registered: int <= (DONE & IE_DONE) | (ERR & IE_ERR).

## Timing
- Reset values: hrdata=0, int=0, acc_valid_out=0, acc_ready_out=0, acc_mode=0, acc_data_out=0. All registers 0; FIFOs empty; OUT_CNT=0.
- Latency:
  - Bus push to acc_valid_out: 1 cycle after the data phase.
  - Core accept to out_empty=0 visible in STATUS: 1 cycle.
  - DONE or ERR set to int: 1 cycle.
- Simultaneous push and pop on the same FIFO:
  - Not full and not empty: level unchanged.
  - Full: push refused (ERR on the bus side; stream side sees ready low).
  - Empty: pop refused.
- CLR empties both FIFOs and zeroes OUT_CNT in the cycle after the write; any same-cycle push or pop is discarded. DONE and ERR are not affected.
- A W1C clear coinciding with a hardware set: the set wins.
- Reset asserted mid-frame: all state returns to reset values immediately; no partial frame survives.

## Configuration
- CM3_STREAM_ACC_THRESH_EN defined:
  - Adds THRESH (0x18, RW, 8 bits) and STATUS[6] THR, which is high while out_level ≥ THRESH and THRESH≠0 (not sticky).
  - Adds CTRL[8] IE_THR; int also includes THR & IE_THR.
- Undefined: 0x18 reads 0, STATUS[6]=0, CTRL[8] reads 0.

## Test plan
- Reset, then read all registers -> every value 0; STATUS=0x0000000A (both FIFOs empty); int=0.
- EN=1, FRAME_LEN=4, push 4 words, core loops data back with acc_ready_in=1 -> OUT_CNT 1,2,3,0; DONE=1; with IE_DONE=1, int=1 one cycle later; W1C of DONE drops int on the next cycle.
- IN_DEPTH=16, EN=0, push 17 words -> in_level=16; ERR=1; 17th word absent from later pops.
- Read OUT_DATA while the output FIFO is empty -> hrdata=0; ERR=1; out_level stays 0.
- Fill the input FIFO to 5 words, write CTRL.CLR=1 in the same cycle as a push -> in_level=0 next cycle; DONE and ERR unchanged.
- With CM3_STREAM_ACC_THRESH_EN defined: THRESH=3, IE_THR=1 -> int rises one cycle after out_level reaches 3 and falls after pops bring it to 2.

Source files
------------

// File: rtl/cm3_stream_acc_if.sv
// cm3_stream_acc_if - AHB-Lite slave front end for valid/ready streaming cores.
//
// An input FIFO (bus -> core) and an output FIFO (core -> bus) sit between
// the bus and the core. Output words are counted per frame. A level
// interrupt fires on frame completion or on a bus-side FIFO error.
//
// Optional feature macro: CM3_STREAM_ACC_THRESH_EN adds the following.
//   - THRESH register at 0x18.
//   - STATUS[6] THR, an output-level threshold flag.
//   - CTRL[8] IE_THR, its interrupt enable.
//
// Ports:
//   hclk, rst_n          clock, asynchronous active-low reset
//   hready_i, hsel,      AHB-Lite address-phase controls
//   hwrite, htrans,
//   haddr
//   hwdata               write data (data phase)
//   hresp, hready_o      tied OKAY / zero wait states
//   hrdata               read data (data phase)
//   int_o                registered level interrupt
//   acc_data_out, acc_valid_out, acc_ready_in
//                        input-FIFO head to the core
//   acc_data_in, acc_valid_in, acc_ready_out
//                        core results into the output FIFO
//   acc_mode             CTRL.MODE forwarded to the core
module cm3_stream_acc_if #(
  parameter int DW        = 32,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int FRAME_W   = 10
) (
  input  logic          hclk,
  input  logic          rst_n,
  input  logic          hready_i,
  input  logic          hsel,
  input  logic          hwrite,
  input  logic [1:0]    htrans,
  input  logic [15:0]   haddr,
  input  logic [31:0]   hwdata,
  output logic          hresp,
  output logic          hready_o,
  output logic [31:0]   hrdata,
  output logic          int_o,
  output logic [DW-1:0] acc_data_out,
  output logic          acc_valid_out,
  input  logic          acc_ready_in,
  input  logic [DW-1:0] acc_data_in,
  input  logic          acc_valid_in,
  output logic          acc_ready_out,
  output logic [3:0]    acc_mode
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  typedef enum logic [2:0] {
    A_CTRL   = 3'd0,
    A_STATUS = 3'd1,
    A_FLEN   = 3'd2,
    A_IN     = 3'd3,
    A_OUT    = 3'd4,
    A_CNT    = 3'd5,
    A_THR    = 3'd6
  } addr_e;

  assign hresp    = 1'b0;
  assign hready_o = 1'b1;

  // Address bits outside the decode field are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{haddr[15:5], haddr[1:0]};

  // ---------------- bus pipeline ----------------
  logic  dp_valid_q, dp_write_q;
  addr_e dp_addr_q;

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= A_CTRL;
    end else begin
      dp_valid_q <= hsel & hready_i & htrans[1];
      dp_write_q <= hwrite;
      dp_addr_q  <= addr_e'(haddr[4:2]);
    end
  end

  logic wr_en, rd_en;
  assign wr_en = dp_valid_q & dp_write_q;
  assign rd_en = dp_valid_q & ~dp_write_q;

  logic wr_ctrl, wr_status, wr_flen, wr_in, rd_out;
  assign wr_ctrl   = wr_en && (dp_addr_q == A_CTRL);
  assign wr_status = wr_en && (dp_addr_q == A_STATUS);
  assign wr_flen   = wr_en && (dp_addr_q == A_FLEN);
  assign wr_in     = wr_en && (dp_addr_q == A_IN);
  assign rd_out    = rd_en && (dp_addr_q == A_OUT);

  logic clr;
  assign clr = wr_ctrl & hwdata[3];

  // ---------------- registers ----------------
  logic               en_q, ie_done_q, ie_err_q;
  logic [3:0]         mode_q;
  logic [FRAME_W-1:0] frame_len_q, out_cnt_q, out_cnt_d;
  logic               done_q, done_d, err_q, err_d, int_q;
  logic               done_set, err_set, thr, ie_thr;

  // ---------------- FIFOs ----------------
  logic [DW-1:0] in_mem  [IN_DEPTH];
  logic [DW-1:0] out_mem [OUT_DEPTH];
  logic [IAW:0]  in_wp_q, in_rp_q, in_level;
  logic [OAW:0]  out_wp_q, out_rp_q, out_level;
  logic          in_full, in_empty, out_full, out_empty;
  logic          in_push, in_pop, out_push, out_pop;

  assign in_level  = in_wp_q - in_rp_q;
  assign out_level = out_wp_q - out_rp_q;
  assign in_empty  = (in_level == '0);
  assign out_empty = (out_level == '0);
  assign in_full   = (in_level == (IAW+1)'(IN_DEPTH));
  assign out_full  = (out_level == (OAW+1)'(OUT_DEPTH));

  assign acc_valid_out = en_q & ~in_empty;
  assign acc_ready_out = en_q & ~out_full;
  assign acc_data_out  = in_empty ? '0 : in_mem[in_rp_q[IAW-1:0]];
  assign acc_mode      = mode_q;

  assign in_push  = wr_in & ~in_full;
  assign in_pop   = acc_valid_out & acc_ready_in;
  assign out_push = acc_valid_in & acc_ready_out;
  assign out_pop  = rd_out & ~out_empty;
  assign err_set  = (wr_in & in_full) | (rd_out & out_empty);

  // NOTE: storage arrays have no reset; pointers alone define contents and
  // the empty FIFO head is masked to 0, so unreset data is never observed.
  always_ff @(posedge hclk) begin
    if (in_push)  in_mem[in_wp_q[IAW-1:0]]   <= hwdata[DW-1:0];
    if (out_push) out_mem[out_wp_q[OAW-1:0]] <= acc_data_in;
  end

  // CLR wins over any same-cycle pointer movement.
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      in_wp_q  <= '0;
      in_rp_q  <= '0;
      out_wp_q <= '0;
      out_rp_q <= '0;
    end else if (clr) begin
      in_wp_q  <= '0;
      in_rp_q  <= '0;
      out_wp_q <= '0;
      out_rp_q <= '0;
    end else begin
      in_wp_q  <= in_wp_q + (IAW+1)'(in_push);
      in_rp_q  <= in_rp_q + (IAW+1)'(in_pop);
      out_wp_q <= out_wp_q + (OAW+1)'(out_push);
      out_rp_q <= out_rp_q + (OAW+1)'(out_pop);
    end
  end

`ifdef CM3_STREAM_ACC_THRESH_EN
  logic [7:0] thresh_q;
  logic       ie_thr_q;
  assign ie_thr = ie_thr_q;
  // Non-sticky: follows the live output level.
  assign thr    = (thresh_q != 8'd0) && (8'(out_level) >= thresh_q);

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q <= '0;
      ie_thr_q <= 1'b0;
    end else begin
      if (wr_en && (dp_addr_q == A_THR)) thresh_q <= hwdata[7:0];
      if (wr_ctrl)                       ie_thr_q <= hwdata[8];
    end
  end
`else
  assign ie_thr = 1'b0;
  assign thr    = 1'b0;
`endif

  // Frame counter, sticky flags. A hardware set beats a same-cycle W1C.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    out_cnt_d = out_cnt_q;
    done_set  = 1'b0;
    if (clr) begin
      out_cnt_d = '0;
    end else if (out_push) begin
      if ((frame_len_q != '0) && (out_cnt_q + 1'b1 == frame_len_q)) begin
        out_cnt_d = '0;
        done_set  = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end
    done_d = done_q;
    err_d  = err_q;
    if (wr_status && hwdata[4]) done_d = 1'b0;
    if (wr_status && hwdata[5]) err_d  = 1'b0;
    if (done_set) done_d = 1'b1;
    if (err_set)  err_d  = 1'b1;
  end

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      ie_done_q   <= 1'b0;
      ie_err_q    <= 1'b0;
      mode_q      <= '0;
      frame_len_q <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en_q      <= hwdata[0];
        ie_done_q <= hwdata[1];
        ie_err_q  <= hwdata[2];
        mode_q    <= hwdata[7:4];
      end
      if (wr_flen) frame_len_q <= hwdata[FRAME_W-1:0];
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      int_q     <= (done_q & ie_done_q) | (err_q & ie_err_q) | (thr & ie_thr);
    end
  end

  assign int_o = int_q;

  // ---------------- read mux (data phase, combinational) ----------------
  always_comb begin
    hrdata = '0;
    if (rd_en) begin
      unique case (dp_addr_q)
        A_CTRL:   hrdata = {23'd0, ie_thr, mode_q, 1'b0, ie_err_q, ie_done_q, en_q};
        A_STATUS: hrdata = {8'd0, 8'(out_level), 8'(in_level), 1'b0, thr, err_q,
                            done_q, out_empty, out_full, in_empty, in_full};
        A_FLEN:   hrdata = 32'(frame_len_q);
        A_OUT:    hrdata = out_empty ? '0 : 32'(out_mem[out_rp_q[OAW-1:0]]);
        A_CNT:    hrdata = 32'(out_cnt_q);
`ifdef CM3_STREAM_ACC_THRESH_EN
        A_THR:    hrdata = 32'(thresh_q);
`endif
        default:  hrdata = '0;
      endcase
    end
  end

endmodule
